// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-array signals around the instruction memory arbiter
interface imem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
);
  localparam int IW = $clog2(MEM_SIZE);
  logic                  fetch_req_i;
  logic [ADDR_WIDTH-1:0] fetch_addr_i;
  logic                  fetch_gnt_o;
  logic                  fetch_rvalid_o;
  logic [DATA_WIDTH-1:0] fetch_rdata_o;
  logic                  ld_req_i;
  logic                  ld_we_i;
  logic [ADDR_WIDTH-1:0] ld_addr_i;
  logic [DATA_WIDTH-1:0] ld_wdata_i;
  logic                  ld_done_i;
  logic                  ld_gnt_o;
  logic                  ld_rvalid_o;
  logic [DATA_WIDTH-1:0] ld_rdata_o;
  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [IW-1:0]         mem_index_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  core_halt_o;
  logic                  err_o;
  modport slave (
    input  fetch_req_i, fetch_addr_i, ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_done_i, mem_rdata_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o,
           mem_en_o, mem_we_o, mem_index_o, mem_wdata_o, core_halt_o, err_o
  );
  modport master (
    output fetch_req_i, fetch_addr_i, ld_req_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_done_i, mem_rdata_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, ld_gnt_o, ld_rvalid_o, ld_rdata_o,
           mem_en_o, mem_we_o, mem_index_o, mem_wdata_o, core_halt_o, err_o
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: boot gating, loader-priority arbitration with fetch anti-starvation, address checks
module imem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  imem_arbiter_if.slave bus
);
  localparam int IW = $clog2(MEM_SIZE);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
  typedef enum logic {BOOT, RUN} state_t;
  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       f_pend_q, f_bad_q, l_pend_q, l_bad_q;
  logic       f_bad, l_bad, f_gnt, l_gnt;
  function automatic logic bad_addr(input logic [ADDR_WIDTH-1:0] a);
    return a[1:0] != 2'b00 || a[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_SIZE);
  endfunction
  assign f_bad = bad_addr(bus.fetch_addr_i);
  assign l_bad = bad_addr(bus.ld_addr_i);
  always_comb begin
    state_d  = (state_q == BOOT && bus.ld_done_i) ? RUN : state_q;
    f_gnt    = !rst && state_q == RUN && bus.fetch_req_i &&
               (!bus.ld_req_i || starve_q >= 4'(STARVE_LIMIT));
    l_gnt    = !rst && bus.ld_req_i && !f_gnt;
    // only loader grants that leave a waiting fetch behind count toward starvation
    starve_d = f_gnt ? 4'd0 :
               (l_gnt && bus.fetch_req_i && state_q == RUN) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      starve_q <= '0;
      f_pend_q <= 1'b0;
      f_bad_q  <= 1'b0;
      l_pend_q <= 1'b0;
      l_bad_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      f_pend_q <= f_gnt;
      f_bad_q  <= f_bad;
      l_pend_q <= l_gnt && !bus.ld_we_i;
      l_bad_q  <= l_bad;
    end
  end
  assign bus.fetch_gnt_o    = f_gnt;
  assign bus.ld_gnt_o       = l_gnt;
  assign bus.core_halt_o    = state_q == BOOT;
  assign bus.err_o          = (f_gnt && f_bad) || (l_gnt && l_bad);
  assign bus.mem_en_o       = (f_gnt && !f_bad) || (l_gnt && !l_bad);
  assign bus.mem_we_o       = l_gnt && bus.ld_we_i && !l_bad;
  assign bus.mem_index_o    = f_gnt ? bus.fetch_addr_i[IW+1:2] : l_gnt ? bus.ld_addr_i[IW+1:2] : '0;
  assign bus.mem_wdata_o    = (l_gnt && bus.ld_we_i) ? bus.ld_wdata_i : '0;
  assign bus.fetch_rvalid_o = f_pend_q;
  assign bus.fetch_rdata_o  = !f_pend_q ? '0 : f_bad_q ? NOP : bus.mem_rdata_i;
  assign bus.ld_rvalid_o    = l_pend_q;
  assign bus.ld_rdata_o     = (l_pend_q && !l_bad_q) ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_imem_arbiter;
  localparam int DW = 32, AW = 32, MS = 1024, SL = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  imem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) bus ();
  imem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [31:0] mem [MS];
  always @(posedge clk)
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_index_o] <= bus.mem_wdata_o;
      else bus.mem_rdata_i <= mem[bus.mem_index_o];
    end
  int n_cmp = 0, n_bad = 0;

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] wd, input logic done);
    @(negedge clk);
    bus.fetch_req_i = fr; bus.fetch_addr_i = fa;
    bus.ld_req_i = lr; bus.ld_we_i = lw; bus.ld_addr_i = la; bus.ld_wdata_i = wd; bus.ld_done_i = done;
    #1;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    idle();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    logic [3*DW+2*10+DW+8-1:0] outs;
    bus.fetch_req_i = 1; bus.ld_req_i = 1; bus.ld_we_i = 1; bus.ld_addr_i = 0; bus.ld_wdata_i = 32'h55;
    #1;
    outs = {bus.fetch_gnt_o, bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.ld_gnt_o, bus.ld_rvalid_o,
            bus.ld_rdata_o, bus.mem_en_o, bus.mem_we_o, bus.mem_index_o, bus.mem_wdata_o, bus.err_o};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs); end
    n_cmp++; if (bus.core_halt_o !== 1'b1) begin n_bad++; $display("FAIL reset_halt: got %b want 1", bus.core_halt_o); end
    idle();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_boot_gating;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (bus.fetch_gnt_o !== 1'b0) begin n_bad++; $display("FAIL boot_gnt[%0d]: got %b want 0", i, bus.fetch_gnt_o); end
      n_cmp++; if (bus.core_halt_o !== 1'b1) begin n_bad++; $display("FAIL boot_halt[%0d]: got %b want 1", i, bus.core_halt_o); end
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (bus.fetch_gnt_o !== 1'b0) begin n_bad++; $display("FAIL boot_done_gnt: got %b want 0", bus.fetch_gnt_o); end
    drive(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.core_halt_o !== 1'b0) begin n_bad++; $display("FAIL run_halt: got %b want 0", bus.core_halt_o); end
    n_cmp++; if (bus.fetch_gnt_o !== 1'b1) begin n_bad++; $display("FAIL run_gnt: got %b want 1", bus.fetch_gnt_o); end
    idle();
    n_cmp++; if (bus.fetch_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL run_rvalid: got %b want 1", bus.fetch_rvalid_o); end
  endtask

  task automatic test_load_then_fetch;
    do_reset();
    drive(0, 0, 1, 1, 0, 32'h0010_0093, 0);
    n_cmp++; if ({bus.ld_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_index_o, bus.mem_wdata_o} !== {3'b111, 10'd0, 32'h0010_0093})
      begin n_bad++; $display("FAIL ld_wr0: got %b%b%b %h %h want 111 0 00100093", bus.ld_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_index_o, bus.mem_wdata_o); end
    drive(0, 0, 1, 1, 4, 32'h0020_0113, 1);
    n_cmp++; if ({bus.ld_gnt_o, bus.mem_index_o, bus.core_halt_o} !== {1'b1, 10'd1, 1'b1})
      begin n_bad++; $display("FAIL ld_wr1_done: got gnt %b idx %h halt %b want 1 1 1", bus.ld_gnt_o, bus.mem_index_o, bus.core_halt_o); end
    drive(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if ({bus.core_halt_o, bus.fetch_gnt_o, bus.mem_index_o, bus.ld_rvalid_o} !== {1'b0, 1'b1, 10'd0, 1'b0})
      begin n_bad++; $display("FAIL fetch0: got halt %b gnt %b idx %h ldrv %b want 0 1 0 0", bus.core_halt_o, bus.fetch_gnt_o, bus.mem_index_o, bus.ld_rvalid_o); end
    drive(1, 4, 0, 0, 0, 0, 0);
    n_cmp++; if ({bus.fetch_gnt_o, bus.mem_index_o} !== {1'b1, 10'd1})
      begin n_bad++; $display("FAIL fetch4: got gnt %b idx %h want 1 1", bus.fetch_gnt_o, bus.mem_index_o); end
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o} !== {1'b1, 32'h0010_0093})
      begin n_bad++; $display("FAIL fetch0_data: got %b %h want 1 00100093", bus.fetch_rvalid_o, bus.fetch_rdata_o); end
    idle();
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o} !== {1'b1, 32'h0020_0113})
      begin n_bad++; $display("FAIL fetch4_data: got %b %h want 1 00200113", bus.fetch_rvalid_o, bus.fetch_rdata_o); end
    idle();
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o} !== 33'd0)
      begin n_bad++; $display("FAIL fetch_idle: got %b %h want 0 0", bus.fetch_rvalid_o, bus.fetch_rdata_o); end
  endtask

  task automatic test_starvation;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 1, 0, 8, 0, 0);
      n_cmp++; if ({bus.fetch_gnt_o, bus.ld_gnt_o} !== ((i % 5 == 4) ? 2'b10 : 2'b01))
        begin n_bad++; $display("FAIL starve[%0d]: got fg/lg %b%b want %b", i, bus.fetch_gnt_o, bus.ld_gnt_o, (i % 5 == 4) ? 2'b10 : 2'b01); end
    end
    idle();
  endtask

  task automatic test_misaligned;
    drive(1, 2, 0, 0, 0, 0, 0);
    n_cmp++; if ({bus.fetch_gnt_o, bus.err_o, bus.mem_en_o} !== 3'b110)
      begin n_bad++; $display("FAIL misal: got gnt/err/en %b%b%b want 110", bus.fetch_gnt_o, bus.err_o, bus.mem_en_o); end
    drive(1, 32'h1000, 0, 0, 0, 0, 0);
    n_cmp++; if ({bus.fetch_gnt_o, bus.err_o, bus.mem_en_o} !== 3'b110)
      begin n_bad++; $display("FAIL oor_fetch: got gnt/err/en %b%b%b want 110", bus.fetch_gnt_o, bus.err_o, bus.mem_en_o); end
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o} !== {1'b1, 32'h13})
      begin n_bad++; $display("FAIL misal_nop: got %b %h want 1 00000013", bus.fetch_rvalid_o, bus.fetch_rdata_o); end
    drive(0, 0, 1, 0, 3, 0, 0);
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.err_o, bus.mem_en_o} !== {1'b1, 32'h13, 2'b10})
      begin n_bad++; $display("FAIL oor_nop: got %b %h err %b en %b want 1 00000013 1 0", bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.err_o, bus.mem_en_o); end
    idle();
    n_cmp++; if ({bus.ld_rvalid_o, bus.ld_rdata_o, bus.err_o} !== {1'b1, 32'h0, 1'b0})
      begin n_bad++; $display("FAIL bad_ld_read: got %b %h err %b want 1 0 0", bus.ld_rvalid_o, bus.ld_rdata_o, bus.err_o); end
  endtask

  task automatic test_oor_write;
    drive(0, 0, 1, 1, 32'h1000, 32'hdead_beef, 0);
    n_cmp++; if ({bus.ld_gnt_o, bus.err_o, bus.mem_en_o, bus.mem_we_o} !== 4'b1100)
      begin n_bad++; $display("FAIL oor_wr: got gnt/err/en/we %b%b%b%b want 1100", bus.ld_gnt_o, bus.err_o, bus.mem_en_o, bus.mem_we_o); end
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if ({bus.ld_rvalid_o, bus.mem_en_o, bus.mem_we_o} !== 3'b010)
      begin n_bad++; $display("FAIL oor_wr_norv: got rv/en/we %b%b%b want 010", bus.ld_rvalid_o, bus.mem_en_o, bus.mem_we_o); end
    idle();
    n_cmp++; if ({bus.ld_rvalid_o, bus.ld_rdata_o} !== {1'b1, 32'h0010_0093})
      begin n_bad++; $display("FAIL oor_wr_keep: got %b %h want 1 00100093", bus.ld_rvalid_o, bus.ld_rdata_o); end
  endtask

  task automatic test_reset_mid_read;
    drive(1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (bus.fetch_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rmr_gnt: got %b want 1", bus.fetch_gnt_o); end
    @(negedge clk);
    rst = 1;
    #1;
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.core_halt_o} !== {1'b0, 32'h0, 1'b1})
      begin n_bad++; $display("FAIL rmr_drop: got rv %b data %h halt %b want 0 0 1", bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.core_halt_o); end
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++; if ({bus.fetch_gnt_o, bus.fetch_rvalid_o, bus.core_halt_o} !== 3'b001)
      begin n_bad++; $display("FAIL rmr_boot: got gnt %b rv %b halt %b want 0 0 1", bus.fetch_gnt_o, bus.fetch_rvalid_o, bus.core_halt_o); end
    idle();
  endtask

  function automatic logic [31:0] pick_addr();
    int r = $urandom_range(0, 9);
    return (r < 8) ? 32'(r * 4) : (r == 8) ? 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3))
                                           : 32'h1000 + 32'($urandom_range(0, 255) * 4);
  endfunction

  task automatic test_random;
    logic [31:0] ref_mem [8];
    int starve = 0;
    logic exp_fv = 0, exp_lv = 0;
    logic [31:0] exp_fd = 0, exp_ld = 0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      drive(0, 0, 1, 1, 32'(i * 4), ref_mem[i], i == 7);
    end
    for (int c = 0; c < 400; c++) begin
      logic fr, lr, lw, done, efg, elg, fb, lb;
      logic [31:0] fa, la, wd;
      fr = 1'($urandom_range(0, 3) != 0); lr = 1'($urandom_range(0, 2) != 0); lw = 1'($urandom);
      fa = pick_addr(); la = pick_addr(); wd = $urandom; done = 1'($urandom_range(0, 15) == 0);
      fb = fa[1:0] != 0 || fa >= 4 * MS;
      lb = la[1:0] != 0 || la >= 4 * MS;
      efg = fr && (!lr || starve >= SL);
      elg = lr && !efg;
      drive(fr, fa, lr, lw, la, wd, done);
      n_cmp++; if ({bus.fetch_gnt_o, bus.ld_gnt_o} !== {efg, elg})
        begin n_bad++; $display("FAIL rnd_gnt[%0d]: got fg/lg %b%b want %b%b", c, bus.fetch_gnt_o, bus.ld_gnt_o, efg, elg); end
      n_cmp++; if ({bus.err_o, bus.mem_en_o, bus.core_halt_o} !== {(efg && fb) || (elg && lb), (efg && !fb) || (elg && !lb), 1'b0})
        begin n_bad++; $display("FAIL rnd_ctl[%0d]: got err/en/halt %b%b%b", c, bus.err_o, bus.mem_en_o, bus.core_halt_o); end
      n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o} !== {exp_fv, exp_fv ? exp_fd : 32'h0})
        begin n_bad++; $display("FAIL rnd_fetch[%0d]: got %b %h want %b %h", c, bus.fetch_rvalid_o, bus.fetch_rdata_o, exp_fv, exp_fd); end
      n_cmp++; if ({bus.ld_rvalid_o, bus.ld_rdata_o} !== {exp_lv, exp_lv ? exp_ld : 32'h0})
        begin n_bad++; $display("FAIL rnd_ld[%0d]: got %b %h want %b %h", c, bus.ld_rvalid_o, bus.ld_rdata_o, exp_lv, exp_ld); end
      starve = efg ? 0 : (elg && fr) ? starve + 1 : starve;
      exp_fv = efg;
      exp_fd = fb ? 32'h13 : ref_mem[fa[4:2]];
      exp_lv = elg && !lw;
      exp_ld = lb ? 32'h0 : ref_mem[la[4:2]];
      if (elg && lw && !lb) ref_mem[la[4:2]] = wd;
    end
    idle();
    n_cmp++; if ({bus.fetch_rvalid_o, bus.fetch_rdata_o} !== {exp_fv, exp_fv ? exp_fd : 32'h0})
      begin n_bad++; $display("FAIL rnd_tail: got %b %h want %b %h", bus.fetch_rvalid_o, bus.fetch_rdata_o, exp_fv, exp_fd); end
  endtask

  initial begin
    for (int i = 0; i < MS; i++) mem[i] = '0;
    bus.mem_rdata_i = '0;
    bus.fetch_req_i = 0; bus.fetch_addr_i = 0; bus.ld_req_i = 0; bus.ld_we_i = 0;
    bus.ld_addr_i = 0; bus.ld_wdata_i = 0; bus.ld_done_i = 0;
    test_reset();
    test_boot_gating();
    test_load_then_fetch();
    test_starvation();
    test_misaligned();
    test_oor_write();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
